axi_ready_policy_gen: RTL and testbench
=======================================

// Module: axi_ready_policy_gen
// PURPOSE
// Synthesizable multi-channel AXI READY pattern generator for the ex_sim block design. It drives
// the ready inputs of up to NUM_CH AXI channels (AW/W/B/AR/R) with a per-channel policy:
// no-backpressure, fixed duty, LFSR random or ready-after-valid. It also records per-channel
// stall statistics, so benches can sweep backpressure without driver-side ready generation.
// PARAMETERS
// NUM_CH     5       number of independent channels (1..16)
// CNT_W      8       width of low/high phase counters (max phase = 2**CNT_W-1 cycles)
// MAX_STALL  64      consecutive valid&!ready cycles that force ready high; 0 disables
// SEED       16'hACE1  base LFSR seed; channel c seeded SEED ^ (16'h1111*(c+1)); 0 remapped to 1
// PORTS
// clock      in   1                clock; all logic on rising edge
// reset      in   1                synchronous, active-high reset
// valid      in   NUM_CH           per-channel VALID observed from the AXI channel
// ready      out  NUM_CH           per-channel READY, registered
// cfg_wr     in   1                config write strobe (one cycle)
// cfg_ch     in   $clog2(NUM_CH)+1 target channel; values >= NUM_CH are ignored
// cfg_mode   in   2                0 NO_BP, 1 FIXED, 2 RANDOM, 3 AFTER_VALID
// cfg_low    in   CNT_W            low-phase / delay cycles
// cfg_high   in   CNT_W            high-phase cycles (FIXED); 0 treated as 1
// cfg_prob   in   8                RANDOM threshold: ready when lfsr[7:0] <= cfg_prob
// stat_clr   in   1                clear all stall counters
// stall_cnt  out  16*NUM_CH        per-channel saturating count of valid&!ready cycles
// BEHAVIOUR
// - Reset: ready=0, stall_cnt=0, all channels mode NO_BP, low=0, high=1, prob=8'hFF, LFSRs seeded,
//   FSMs IDLE. In NO_BP mode, ready=1 on the first edge after reset deasserts.
// - Handshake hs[c] = valid[c] & ready[c] (ready is the registered output).
// - cfg_wr: the new config is used from the next cycle. That channel's phase counter, stall-run
//   counter and FSM restart. A handshake in the same cycle still completes and counts normally.
// - NO_BP: ready=1 every cycle.
// - FIXED: FSM LOW -> HIGH -> LOW. LOW lasts cfg_low cycles, HIGH lasts max(cfg_high,1). Entry is
//   in LOW. If cfg_low=0, ready is constant 1. Pattern is free-running and independent of valid.
// - RANDOM: a 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) advances every cycle.
//   ready_next = (lfsr[7:0] <= cfg_prob). prob=8'hFF gives constant 1.
// - AFTER_VALID: FSM IDLE -> WAIT -> RDY -> IDLE.
//   IDLE: ready=0. When valid=1 is sampled in cycle t, go to WAIT with count=cfg_low.
//   WAIT: counts down; ready is first visible high in cycle t+1+cfg_low (t+1 if cfg_low=0).
//   RDY: ready held high until hs, then ready=0 and back to IDLE on the next cycle.
//   valid dropping before hs (AXI violation): return to IDLE, ready=0.
// - Watchdog (MAX_STALL>0, all modes): a run counter increments on valid&!ready and clears on hs
//   or valid=0. When it reaches MAX_STALL, ready is forced to 1 from the next cycle until hs.
//   This guarantees forward progress.
// - stall_cnt[c] increments on valid&!ready and saturates at 16'hFFFF. stat_clr has priority
//   over increment (result 0).
// - Reset mid-transfer aborts all FSMs; ready=0 in the cycle after reset is sampled.
// TESTING
// T1 reset 3 cycles, NUM_CH=5 defaults -> ready=5'b00000 during reset, 5'b11111 first cycle
//    after; 10 valid pulses -> stall_cnt all 0.
// T2 cfg ch2 FIXED low=3 high=2 -> ready[2] = 0,0,0,1,1 repeating from cycle after cfg_wr;
//    other channels stay 1.
// T3 cfg ch0 AFTER_VALID low=2; valid[0] rises cycle t and is held -> ready[0]=1 at t+3,
//    hs at t+3, ready[0]=0 at t+4; stall_cnt[0]=3.
// T4 cfg ch4 RANDOM prob=0, MAX_STALL=8, valid held -> ready[4] high no later than stall 9;
//    hs occurs; stall_cnt[4] <= 8.
// T5 RANDOM prob=255 over 1000 cycles -> ready constant 1. Separately, valid held with
//    ready=0 for 70000 cycles -> stall_cnt=16'hFFFF.
// T6 stat_clr coincident with stall -> counter 0. cfg_wr with cfg_ch=7 (NUM_CH=5) -> no
//    channel config changes.

Source files
------------

// File: rtl/axi_ready_policy_gen.sv
// -----------------------------------------------------------------------------
// axi_ready_policy_gen
// Multi-channel AXI READY pattern generator. Each channel drives a registered
// READY according to its own policy (no backpressure, fixed duty, LFSR random,
// or ready-after-valid). It also keeps a saturating per-channel stall counter.
// A watchdog forces READY high after MAX_STALL consecutive stalls so a
// transfer always makes progress.
//
// Ports
//   clock      in   1                 rising-edge clock
//   reset      in   1                 synchronous active-high reset
//   valid      in   NUM_CH            per-channel VALID observed on the bus
//   ready      out  NUM_CH            per-channel READY (registered)
//   cfg_wr     in   1                 config write strobe
//   cfg_ch     in   $clog2(NUM_CH)+1  target channel (>= NUM_CH ignored)
//   cfg_mode   in   2                 0 NO_BP, 1 FIXED, 2 RANDOM, 3 AFTER_VALID
//   cfg_low    in   CNT_W             low-phase / delay cycles
//   cfg_high   in   CNT_W             high-phase cycles (0 behaves as 1)
//   cfg_prob   in   8                 RANDOM: ready when lfsr[7:0] <= cfg_prob
//   stat_clr   in   1                 clear all stall counters
//   stall_cnt  out  16*NUM_CH         per-channel saturating valid&!ready count
// -----------------------------------------------------------------------------
module axi_ready_policy_gen #(
   parameter int          NUM_CH    = 5,
   parameter int          CNT_W     = 8,
   parameter int          MAX_STALL = 64,
   parameter logic [15:0] SEED      = 16'hACE1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NUM_CH-1:0]       valid,
   output logic [NUM_CH-1:0]       ready,
   input  logic                    cfg_wr,
   input  logic [$clog2(NUM_CH):0] cfg_ch,
   input  logic [1:0]              cfg_mode,
   input  logic [CNT_W-1:0]        cfg_low,
   input  logic [CNT_W-1:0]        cfg_high,
   input  logic [7:0]              cfg_prob,
   input  logic                    stat_clr,
   output logic [16*NUM_CH-1:0]    stall_cnt
);
   localparam int CH_W  = $clog2(NUM_CH) + 1;
   localparam int RUN_W = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;

   localparam logic [1:0] MODE_NO_BP  = 2'd0;
   localparam logic [1:0] MODE_FIXED  = 2'd1;
   localparam logic [1:0] MODE_RANDOM = 2'd2;
   localparam logic [1:0] MODE_AFTER  = 2'd3;

   typedef enum logic [2:0] {ST_IDLE, ST_LOW, ST_HIGH, ST_WAIT, ST_RDY} state_t;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      localparam logic [15:0] SEED_RAW = SEED ^ 16'(16'h1111 * (gi + 1));
      localparam logic [15:0] SEED_CH  = (SEED_RAW == 16'h0000) ? 16'h0001 : SEED_RAW;

      logic [1:0]       mode_reg;
      logic [CNT_W-1:0] low_reg, high_reg, high_eff;
      logic [7:0]       prob_reg;
      logic [15:0]      lfsr_reg, lfsr_next;
      logic [15:0]      stall_reg;
      state_t           state_reg, state_next, entry_state;
      logic [CNT_W-1:0] cnt_reg, cnt_next, entry_cnt;
      logic [RUN_W-1:0] run_reg, run_next;
      logic             ready_reg, ready_next, pol_ready, force_ready, entry_ready;
      logic             hs, stall, cfg_hit;

      assign hs        = valid[gi] & ready_reg;
      assign stall     = valid[gi] & ~ready_reg;
      assign cfg_hit   = cfg_wr && (cfg_ch == CH_W'(gi));
      assign high_eff  = (high_reg == '0) ? CNT_W'(1) : high_reg;
      // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
      assign lfsr_next = lfsr_reg[0] ? ((lfsr_reg >> 1) ^ 16'hB400) : (lfsr_reg >> 1);

      // Consecutive-stall run; saturates at MAX_STALL so the force persists until hs.
      always_comb begin
         run_next = run_reg;
         if (!stall)
            run_next = '0;
         else if (run_reg != RUN_W'(MAX_STALL))
            run_next = run_reg + RUN_W'(1);
      end

      assign force_ready = (MAX_STALL > 0) && (run_next == RUN_W'(MAX_STALL));
      assign ready_next  = pol_ready | force_ready;

      // Policy next-state / next-ready, plus the entry point used on a config write.
      always_comb begin
         state_next = state_reg;
         cnt_next   = cnt_reg;
         pol_ready  = 1'b1;
         case (mode_reg)
            MODE_FIXED: begin
               if (low_reg == '0) begin
                  state_next = ST_LOW;
                  cnt_next   = '0;
                  pol_ready  = 1'b1;
               end else if (state_reg == ST_HIGH) begin
                  if (cnt_reg >= high_eff) begin
                     state_next = ST_LOW;
                     cnt_next   = CNT_W'(1);
                     pol_ready  = 1'b0;
                  end else begin
                     cnt_next  = cnt_reg + CNT_W'(1);
                     pol_ready = 1'b1;
                  end
               end else begin
                  if (cnt_reg >= low_reg) begin
                     state_next = ST_HIGH;
                     cnt_next   = CNT_W'(1);
                     pol_ready  = 1'b1;
                  end else begin
                     state_next = ST_LOW;
                     cnt_next   = cnt_reg + CNT_W'(1);
                     pol_ready  = 1'b0;
                  end
               end
            end
            MODE_RANDOM: begin
               state_next = ST_IDLE;
               pol_ready  = (lfsr_reg[7:0] <= prob_reg);
            end
            MODE_AFTER: begin
               pol_ready = 1'b0;
               case (state_reg)
                  ST_WAIT: begin
                     // A watchdog-forced handshake also ends the wait.
                     if (!valid[gi] || hs) begin
                        state_next = ST_IDLE;
                     end else if (cnt_reg <= CNT_W'(1)) begin
                        state_next = ST_RDY;
                        pol_ready  = 1'b1;
                     end else begin
                        cnt_next = cnt_reg - CNT_W'(1);
                     end
                  end
                  ST_RDY: begin
                     if (hs || !valid[gi])
                        state_next = ST_IDLE;
                     else
                        pol_ready = 1'b1;
                  end
                  default: begin
                     state_next = ST_IDLE;
                     // valid seen during a handshake belongs to the completed beat
                     if (valid[gi] && !hs) begin
                        if (low_reg == '0) begin
                           state_next = ST_RDY;
                           pol_ready  = 1'b1;
                        end else begin
                           state_next = ST_WAIT;
                           cnt_next   = low_reg;
                        end
                     end
                  end
               endcase
            end
            default: begin
               state_next = ST_IDLE;
               pol_ready  = 1'b1;
            end
         endcase

         entry_state = ST_IDLE;
         entry_cnt   = '0;
         entry_ready = 1'b1;
         case (cfg_mode)
            MODE_FIXED: begin
               entry_state = ST_LOW;
               entry_cnt   = CNT_W'(1);
               entry_ready = (cfg_low == '0);
            end
            MODE_RANDOM: entry_ready = (lfsr_reg[7:0] <= cfg_prob);
            MODE_AFTER:  entry_ready = 1'b0;
            default:     entry_ready = 1'b1;
         endcase
      end

      always_ff @(posedge clock) begin
         if (reset) begin
            mode_reg  <= MODE_NO_BP;
            low_reg   <= '0;
            high_reg  <= CNT_W'(1);
            prob_reg  <= 8'hFF;
            lfsr_reg  <= SEED_CH;
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            run_reg   <= '0;
            ready_reg <= 1'b0;
            stall_reg <= '0;
         end else begin
            lfsr_reg <= lfsr_next;
            if (stat_clr)
               stall_reg <= '0;
            else if (stall && (stall_reg != 16'hFFFF))
               stall_reg <= stall_reg + 16'd1;
            if (cfg_hit) begin
               mode_reg  <= cfg_mode;
               low_reg   <= cfg_low;
               high_reg  <= cfg_high;
               prob_reg  <= cfg_prob;
               state_reg <= entry_state;
               cnt_reg   <= entry_cnt;
               run_reg   <= '0;
               ready_reg <= entry_ready;
            end else begin
               state_reg <= state_next;
               cnt_reg   <= cnt_next;
               run_reg   <= run_next;
               ready_reg <= ready_next;
            end
         end
      end

      assign ready[gi]             = ready_reg;
      assign stall_cnt[16*gi +: 16] = stall_reg;
   end

endmodule

// File: tb/tb_axi_ready_policy_gen.sv
// -----------------------------------------------------------------------------
// tb_axi_ready_policy_gen
// Self-checking bench. Main instance (NUM_CH=5, MAX_STALL=8) is exercised with
// per-cycle vector tables; expected READY values go through a scoreboard queue.
// A second single-channel instance without watchdog runs the long stall
// saturation sequence in parallel.
// -----------------------------------------------------------------------------
module tb_axi_ready_policy_gen;
   localparam int NCH = 5;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic               reset;
   logic [NCH-1:0]     valid, ready;
   logic               cfg_wr;
   logic [3:0]         cfg_ch;
   logic [1:0]         cfg_mode;
   logic [7:0]         cfg_low, cfg_high, cfg_prob;
   logic               stat_clr;
   logic [16*NCH-1:0]  stall_cnt;

   logic               nw_reset;
   logic [0:0]         nw_valid, nw_ready;
   logic               nw_cfg_wr;
   logic [0:0]         nw_cfg_ch;
   logic [1:0]         nw_cfg_mode;
   logic [7:0]         nw_cfg_low, nw_cfg_high, nw_cfg_prob;
   logic               nw_stat_clr;
   logic [15:0]        nw_stall_cnt;

   axi_ready_policy_gen #(.NUM_CH(NCH), .CNT_W(8), .MAX_STALL(8), .SEED(16'hACE1)) dut (
      .clock(clock), .reset(reset), .valid(valid), .ready(ready),
      .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_low(cfg_low),
      .cfg_high(cfg_high), .cfg_prob(cfg_prob), .stat_clr(stat_clr), .stall_cnt(stall_cnt)
   );

   axi_ready_policy_gen #(.NUM_CH(1), .CNT_W(8), .MAX_STALL(0), .SEED(16'hACE1)) dut_nw (
      .clock(clock), .reset(nw_reset), .valid(nw_valid), .ready(nw_ready),
      .cfg_wr(nw_cfg_wr), .cfg_ch(nw_cfg_ch), .cfg_mode(nw_cfg_mode), .cfg_low(nw_cfg_low),
      .cfg_high(nw_cfg_high), .cfg_prob(nw_cfg_prob), .stat_clr(nw_stat_clr),
      .stall_cnt(nw_stall_cnt)
   );

   typedef struct { logic [NCH-1:0] valid; logic [NCH-1:0] exp; logic [NCH-1:0] care; } vec_t;
   typedef struct { string name; logic [NCH-1:0] exp; logic [NCH-1:0] care; } exp_t;

   vec_t vt[$];
   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   stalls, seen, zeros, hi_seen;
   logic [15:0] lm;

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
         $display("ok   %s : %0h", name, act);
      end else begin
         $display("FAIL %s : got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic add_vec(input logic [NCH-1:0] v, input logic [NCH-1:0] e, input logic [NCH-1:0] c);
      vec_t x;
      x.valid = v;
      x.exp   = e;
      x.care  = c;
      vt.push_back(x);
   endtask

   // One vector per cycle; called at posedge+1, returns at posedge+1.
   task automatic apply_vectors(input string name);
      exp_t e;
      exp_t got;
      for (int i = 0; i < vt.size(); i++) begin
         valid  = vt[i].valid;
         e.name = $sformatf("%s[%0d]", name, i);
         e.exp  = vt[i].exp;
         e.care = vt[i].care;
         sb_q.push_back(e);
         @(negedge clock);
         got = sb_q.pop_front();
         check(got.name, 80'(ready & got.care), 80'(got.exp & got.care));
         @(posedge clock);
         #1;
      end
      vt.delete();
   endtask

   task automatic cfg_write(input logic [3:0] ch, input logic [1:0] mode,
                            input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] pr);
      cfg_ch   = ch;
      cfg_mode = mode;
      cfg_low  = lo;
      cfg_high = hi;
      cfg_prob = pr;
      cfg_wr   = 1'b1;
      @(posedge clock);
      #1;
      cfg_wr   = 1'b0;
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      logic [15:0] r;
      r = s >> 1;
      if (s[0]) r = r ^ 16'hB400;
      return r;
   endfunction

   initial begin
      reset = 1'b1; valid = '0; cfg_wr = 1'b0; cfg_ch = '0; cfg_mode = '0;
      cfg_low = '0; cfg_high = 8'd1; cfg_prob = 8'hFF; stat_clr = 1'b0;
      nw_reset = 1'b1; nw_valid = '0; nw_cfg_wr = 1'b0; nw_cfg_ch = '0; nw_cfg_mode = '0;
      nw_cfg_low = '0; nw_cfg_high = 8'd1; nw_cfg_prob = 8'hFF; nw_stat_clr = 1'b0;

      fork
         begin : main_proc
            // T1: reset then NO_BP defaults
            @(posedge clock);
            #1;
            for (int i = 0; i < 3; i++) add_vec('0, '0, 5'h1F);
            apply_vectors("T1 in_reset");
            reset = 1'b0;
            add_vec('0, '0, 5'h1F);
            add_vec('0, 5'h1F, 5'h1F);
            for (int i = 0; i < 10; i++) begin
               add_vec(5'h1F, 5'h1F, 5'h1F);
               add_vec(5'h00, 5'h1F, 5'h1F);
            end
            apply_vectors("T1 nobp");
            check("T1 stall_cnt", 80'(stall_cnt), 80'd0);

            // T2: ch2 FIXED low=3 high=2
            cfg_write(4'd2, 2'd1, 8'd3, 8'd2, 8'hFF);
            for (int i = 0; i < 10; i++)
               add_vec('0, ((i % 5) < 3) ? 5'h1B : 5'h1F, 5'h1F);
            apply_vectors("T2 fixed");
            cfg_write(4'd2, 2'd0, 8'd0, 8'd1, 8'hFF);

            // T3: ch0 AFTER_VALID low=2, valid held until hs
            cfg_write(4'd0, 2'd3, 8'd2, 8'd1, 8'hFF);
            add_vec(5'h00, 5'h1E, 5'h1F);
            add_vec(5'h01, 5'h1E, 5'h1F);
            add_vec(5'h01, 5'h1E, 5'h1F);
            add_vec(5'h01, 5'h1E, 5'h1F);
            add_vec(5'h01, 5'h1F, 5'h1F);
            add_vec(5'h00, 5'h1E, 5'h1F);
            apply_vectors("T3 after_valid");
            check("T3 stall_cnt0", 80'(stall_cnt[15:0]), 80'd3);
            stat_clr = 1'b1;
            @(posedge clock);
            #1;
            stat_clr = 1'b0;
            check("T6 stat_clr ch0", 80'(stall_cnt[15:0]), 80'd0);

            // AFTER_VALID with zero delay, then valid dropped before hs
            cfg_write(4'd0, 2'd3, 8'd0, 8'd1, 8'hFF);
            add_vec(5'h01, 5'h1E, 5'h1F);
            add_vec(5'h01, 5'h1F, 5'h1F);
            add_vec(5'h00, 5'h1E, 5'h1F);
            apply_vectors("T3 delay0");
            cfg_write(4'd0, 2'd3, 8'd2, 8'd1, 8'hFF);
            add_vec(5'h01, 5'h1E, 5'h1F);
            add_vec(5'h00, 5'h1E, 5'h1F);
            add_vec(5'h01, 5'h1E, 5'h1F);
            add_vec(5'h01, 5'h1E, 5'h1F);
            add_vec(5'h01, 5'h1E, 5'h1F);
            add_vec(5'h01, 5'h1F, 5'h1F);
            add_vec(5'h00, 5'h1E, 5'h1F);
            apply_vectors("T3 valid_drop");
            cfg_write(4'd0, 2'd0, 8'd0, 8'd1, 8'hFF);

            // Watchdog on a long FIXED low phase: exactly 8 stalls then forced ready
            cfg_write(4'd1, 2'd1, 8'd20, 8'd1, 8'hFF);
            for (int i = 0; i < 8; i++) add_vec(5'h02, 5'h1D, 5'h1F);
            add_vec(5'h02, 5'h1F, 5'h1F);
            add_vec(5'h00, 5'h1D, 5'h1F);
            apply_vectors("T4 wdog_fixed");
            check("T4 stall_cnt1", 80'(stall_cnt[31:16]), 80'd8);
            cfg_write(4'd1, 2'd0, 8'd0, 8'd1, 8'hFF);

            // T4: ch4 RANDOM prob=0 with valid held
            cfg_write(4'd4, 2'd2, 8'd0, 8'd1, 8'd0);
            valid  = 5'h10;
            stalls = 0;
            seen   = 0;
            for (int i = 0; i < 12 && seen == 0; i++) begin
               @(negedge clock);
               if (ready[4]) seen = 1;
               else stalls++;
               @(posedge clock);
               #1;
            end
            valid = '0;
            check("T4 hs_seen", 80'(seen), 80'd1);
            check("T4 stalls_le_8", 80'(stalls <= 8), 80'd1);
            check("T4 stall_cnt4", 80'(stall_cnt[79:64]), 80'(stalls));
            cfg_write(4'd4, 2'd0, 8'd0, 8'd1, 8'hFF);

            // T5: ch3 RANDOM prob=255 for 1000 cycles
            cfg_write(4'd3, 2'd2, 8'd0, 8'd1, 8'hFF);
            valid = 5'h08;
            zeros = 0;
            for (int i = 0; i < 1000; i++) begin
               @(negedge clock);
               if (ready[3] !== 1'b1) zeros++;
               @(posedge clock);
               #1;
            end
            valid = '0;
            check("T5 prob255_zero_cycles", 80'(zeros), 80'd0);
            check("T5 stall_cnt3", 80'(stall_cnt[63:48]), 80'd0);

            // T6: out-of-range channel is ignored
            cfg_write(4'd7, 2'd1, 8'd3, 8'd2, 8'h00);
            for (int i = 0; i < 6; i++) add_vec('0, 5'h1F, 5'h1F);
            apply_vectors("T6 ch7_ignored");

            // Reset mid-transfer, then predicted LFSR sequence on ch4
            cfg_write(4'd0, 2'd3, 8'd5, 8'd1, 8'hFF);
            valid = 5'h01;
            @(posedge clock);
            #1;
            reset = 1'b1;
            @(posedge clock);
            #1;
            check("RST ready", 80'(ready), 80'd0);
            check("RST stall_cnt", 80'(stall_cnt), 80'd0);
            reset = 1'b0;
            valid = '0;
            lm = 16'hACE1 ^ 16'h5555;
            for (int k = 0; k < 40; k++) begin
               add_vec('0, {(lm[7:0] <= 8'h7F), 4'hF}, 5'h1F);
               lm = lfsr_step(lm);
            end
            cfg_write(4'd4, 2'd2, 8'd0, 8'd1, 8'h7F);
            apply_vectors("RST lfsr_ch4");
         end

         begin : nw_proc
            repeat (2) @(posedge clock);
            #1;
            nw_reset    = 1'b0;
            nw_cfg_mode = 2'd3;
            nw_cfg_low  = 8'd255;
            nw_cfg_ch   = 1'b0;
            nw_valid    = 1'b1;
            hi_seen     = 0;
            // Re-writing the config restarts the delay so ready never rises.
            for (int i = 0; i < 65600; i++) begin
               nw_cfg_wr = ((i % 200) == 0);
               @(negedge clock);
               if (nw_ready[0] !== 1'b0) hi_seen++;
               @(posedge clock);
               #1;
               if (i + 1 == 1000) check("T5 nw stall_cnt_1000", 80'(nw_stall_cnt), 80'd1000);
            end
            nw_cfg_wr = 1'b0;
            check("T5 nw ready_never_high", 80'(hi_seen), 80'd0);
            check("T5 nw stall_cnt_sat", 80'(nw_stall_cnt), 80'hFFFF);
            nw_stat_clr = 1'b1;
            @(posedge clock);
            #1;
            nw_stat_clr = 1'b0;
            check("T6 nw stat_clr_with_stall", 80'(nw_stall_cnt), 80'd0);
            @(posedge clock);
            #1;
            check("T6 nw count_after_clr", 80'(nw_stall_cnt), 80'd1);
            nw_valid = 1'b0;
         end
      join

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
